// File: rtl/switch_allocator_if.sv
// Router-side handshake bundle between route computation, the allocator and the crossbar.
// The master modport is the router/testbench side; the slave modport is the allocator.
interface switch_allocator_if;
  logic [4:0]  in_valid;
  logic [14:0] in_dir;
  logic [4:0]  in_tail;
  logic [4:0]  out_ready;
  logic [4:0]  in_grant;
  logic [4:0]  out_valid;
  logic [14:0] out_sel;
  logic [4:0]  out_locked;
  logic [4:0]  bad_dir;

  modport master (
    output in_valid, in_dir, in_tail, out_ready,
    input  in_grant, out_valid, out_sel, out_locked, bad_dir
  );

  modport slave (
    input  in_valid, in_dir, in_tail, out_ready,
    output in_grant, out_valid, out_sel, out_locked, bad_dir
  );
endinterface

// File: rtl/switch_allocator.sv
// 5-port wormhole switch allocator: per-output round-robin arbitration plus packet lock.
// Define ALLOC_TIMEOUT_EN to add the per-output idle-lock watchdog and timeout_flag port.
module switch_allocator #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  switch_allocator_if.slave bus
`ifdef ALLOC_TIMEOUT_EN
  ,
  output logic [4:0]        timeout_flag
`endif
);
  localparam int NP = 5;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("switch_allocator: TIMEOUT_CYC must be in 1..65535");
  end

  logic [NP-1:0]         lock_vec;
  logic [NP-1:0]         fire_vec;
  logic [NP-1:0]         out_valid_w;
  logic [NP-1:0]         dir_ok;
  logic [NP-1:0]         locked_in;
  logic [NP-1:0]         req_ok;
  logic [NP-1:0]         grant_w;
  logic [NP-1:0]         win_vld;
  logic [NP-1:0]         taken_c;
  logic [NP-1:0]         tmo_flag_vec;
  logic [NP-1:0][2:0]    owner_vec;
  logic [NP-1:0][2:0]    ptr_vec;
  logic [NP-1:0][2:0]    win_idx;
  logic [NP-1:0][NP-1:0] own_oh;
  logic [14:0]           out_sel_w;

  genvar gi;

  for (gi = 0; gi < NP; gi++) begin : g_in
    assign dir_ok[gi] = (bus.in_dir[3*gi +: 3] <= 3'd4);
  end

  always_comb begin
    locked_in = '0;
    grant_w   = '0;
    for (int o = 0; o < NP; o++) begin
      locked_in = locked_in | own_oh[o];
      if (fire_vec[o]) grant_w = grant_w | own_oh[o];
    end
  end

  assign req_ok = bus.in_valid & ~locked_in & dir_ok;

  // Outputs claim inputs in index order; a claimed input drops out for higher outputs.
  always_comb begin
    int idx;
    idx     = 0;
    taken_c = '0;
    win_vld = '0;
    win_idx = '0;
    for (int o = 0; o < NP; o++) begin
      if (!lock_vec[o]) begin
        for (int k = 1; k <= NP; k++) begin
          idx = int'(ptr_vec[o]) + k;
          if (idx >= NP) idx = idx - NP;
          if (!win_vld[o] && req_ok[idx] && !taken_c[idx] &&
              bus.in_dir[3*idx +: 3] == 3'(o)) begin
            win_vld[o] = 1'b1;
            win_idx[o] = 3'(idx);
          end
        end
        if (win_vld[o]) taken_c[win_idx[o]] = 1'b1;
      end
    end
  end

  for (gi = 0; gi < NP; gi++) begin : g_out
    state_t     state_q;
    logic [2:0] owner_q;
    logic [2:0] ptr_q;
    logic       tmo_hit;

    assign lock_vec[gi]        = (state_q == LOCKED);
    assign owner_vec[gi]       = owner_q;
    assign ptr_vec[gi]         = ptr_q;
    assign own_oh[gi]          = lock_vec[gi] ? (NP'(1) << owner_q) : '0;
    assign out_valid_w[gi]     = lock_vec[gi] && bus.in_valid[owner_q];
    assign fire_vec[gi]        = out_valid_w[gi] && bus.out_ready[gi];
    assign out_sel_w[3*gi +: 3] = lock_vec[gi] ? owner_q : 3'd0;

`ifdef ALLOC_TIMEOUT_EN
    logic [15:0] stall_q;
    logic [15:0] stall_d;
    logic        flag_q;

    assign stall_d          = stall_q + 16'd1;
    assign tmo_hit          = lock_vec[gi] && !bus.in_valid[owner_q] &&
                              (stall_d >= 16'(TIMEOUT_CYC));
    assign tmo_flag_vec[gi] = flag_q;

    // Stall counter only advances while the owner has nothing to send.
    always_ff @(posedge clk) begin
      if (rst) begin
        stall_q <= '0;
        flag_q  <= 1'b0;
      end else begin
        if (!lock_vec[gi] || fire_vec[gi] || tmo_hit) stall_q <= '0;
        else if (!bus.in_valid[owner_q])              stall_q <= stall_d;
        if (tmo_hit) flag_q <= 1'b1;
      end
    end
`else
    assign tmo_hit          = 1'b0;
    assign tmo_flag_vec[gi] = 1'b0;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        owner_q <= 3'd0;
        ptr_q   <= 3'd4;
      end else begin
        case (state_q)
          IDLE: begin
            if (win_vld[gi]) begin
              state_q <= LOCKED;
              owner_q <= win_idx[gi];
              ptr_q   <= win_idx[gi];
            end
          end
          LOCKED: begin
            if ((fire_vec[gi] && bus.in_tail[owner_q]) || tmo_hit) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_grant   = grant_w;
  assign bus.out_valid  = out_valid_w;
  assign bus.out_sel    = out_sel_w;
  assign bus.out_locked = lock_vec;
  assign bus.bad_dir    = bus.in_valid & ~locked_in & ~dir_ok;

`ifdef ALLOC_TIMEOUT_EN
  assign timeout_flag = tmo_flag_vec;
`else
  logic unused_ok;
  assign unused_ok = ^{tmo_flag_vec, owner_vec};
`endif
endmodule
